// File: rtl/jtag_dbg_bridge.sv
// Bridge from the debug module's level-style memory request to a granted,
// acknowledged system-bus access, plus core halt and stretched core reset.
module jtag_dbg_bridge #(
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned DATA_BITS  = 32,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_req_i,
  input  logic                 mem_we_i,
  input  logic [ADDR_BITS-1:0] mem_addr_i,
  input  logic [DATA_BITS-1:0] mem_wdata_i,
  output logic [DATA_BITS-1:0] mem_rdata_o,
  input  logic                 halt_req_i,
  input  logic                 reset_req_i,
  output logic                 bus_req_o,
  input  logic                 bus_gnt_i,
  output logic                 bus_we_o,
  output logic [ADDR_BITS-1:0] bus_addr_o,
  output logic [DATA_BITS-1:0] bus_wdata_o,
  input  logic [DATA_BITS-1:0] bus_rdata_i,
  input  logic                 bus_ack_i,
  output logic                 halt_o,
  output logic                 core_rst_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT);
  localparam int unsigned RCNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RST_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_op_q;
  logic                  r_rst_q;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [DATA_BITS-1:0]  r_wdata;
  logic [DATA_BITS-1:0]  r_rdata;
  logic                  r_err;
  logic                  r_bus_req;
  logic                  r_bus_we;
  logic [ADDR_BITS-1:0]  r_bus_addr;
  logic [DATA_BITS-1:0]  r_bus_wdata;
  logic                  r_halt;
  logic [RCNT_W-1:0]     r_rcnt;
  logic                  r_core_rst;
  logic                  r_busy;

  logic                  w_start;
  logic                  w_rst_start;
  logic                  w_acc_nxt;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_we_nxt;
  logic [ADDR_BITS-1:0]  w_addr_nxt;
  logic [DATA_BITS-1:0]  w_wdata_nxt;
  logic [DATA_BITS-1:0]  w_rdata_nxt;
  logic                  w_err_nxt;
  logic                  w_bus_req_nxt;
  logic                  w_bus_we_nxt;
  logic [ADDR_BITS-1:0]  w_bus_addr_nxt;
  logic [DATA_BITS-1:0]  w_bus_wdata_nxt;
  logic                  w_halt_nxt;
  logic [RCNT_W-1:0]     w_rcnt_nxt;
  logic                  w_busy_nxt;

  assign w_start     = op_req_i & ~r_op_q;
  assign w_rst_start = reset_req_i & ~r_rst_q;

  // Next-state and next-output decode; outputs are registered from the next state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_we_nxt    = mem_we_i;
          w_addr_nxt  = mem_addr_i;
          w_wdata_nxt = mem_wdata_i;
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_rst_start) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (bus_gnt_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_ACCESS;
        end else if (r_cnt == CNT_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_ACCESS: begin
        // An ack arriving on the final timeout cycle still completes cleanly
        if (w_rst_start) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (bus_ack_i) begin
          if (!r_we) w_rdata_nxt = bus_rdata_i;
          w_state_nxt = S_DONE;
        end else if (!bus_gnt_i) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!op_req_i) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_acc_nxt       = (w_state_nxt == S_ACCESS);
    w_busy_nxt      = (w_state_nxt == S_REQ) | w_acc_nxt;
    w_bus_req_nxt   = w_busy_nxt;
    w_bus_we_nxt    = w_acc_nxt & w_we_nxt;
    w_bus_addr_nxt  = w_acc_nxt ? w_addr_nxt  : '0;
    w_bus_wdata_nxt = w_acc_nxt ? w_wdata_nxt : '0;
    w_halt_nxt      = halt_req_i | (r_state != S_IDLE);

    // Reset stretcher: a new request edge always reloads the full width
    w_rcnt_nxt = r_rcnt;
    if (w_rst_start) begin
      w_rcnt_nxt = RCNT_LOAD;
    end else if (r_rcnt != '0) begin
      w_rcnt_nxt = r_rcnt - RCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op_q      <= 1'b0;
      r_rst_q     <= 1'b0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_halt      <= 1'b0;
      r_rcnt      <= '0;
      r_core_rst  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op_q      <= op_req_i;
      r_rst_q     <= reset_req_i;
      r_cnt       <= w_cnt_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err       <= w_err_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_halt      <= w_halt_nxt;
      r_rcnt      <= w_rcnt_nxt;
      r_core_rst  <= (w_rcnt_nxt != '0);
      r_busy      <= w_busy_nxt;
    end
  end

  assign mem_rdata_o = r_rdata;
  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;
  assign halt_o      = r_halt;
  assign core_rst_o  = r_core_rst;
  assign busy_o      = r_busy;
  assign err_o       = r_err;

endmodule

// File: tb/tb_jtag_dbg_bridge.sv
// Randomized transaction-level check of jtag_dbg_bridge against an
// arithmetic model of grant/ack timing, timeouts, aborts and reset pulses.
module tb_jtag_dbg_bridge;

  localparam int T  = 8;
  localparam int RC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_req_i, mem_we_i, halt_req_i, reset_req_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic        bus_req_o, bus_gnt_i, bus_we_o, bus_ack_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        halt_o, core_rst_o, busy_o, err_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rdata;

  jtag_dbg_bridge #(
    .ADDR_BITS (32),
    .DATA_BITS (32),
    .TIMEOUT   (T),
    .RST_CYCLES(RC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_req_i   (op_req_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .halt_req_i (halt_req_i),
    .reset_req_i(reset_req_i),
    .bus_req_o  (bus_req_o),
    .bus_gnt_i  (bus_gnt_i),
    .bus_we_o   (bus_we_o),
    .bus_addr_o (bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ack_i  (bus_ack_i),
    .halt_o     (halt_o),
    .core_rst_o (core_rst_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One access. gd: REQ cycles before grant; ad: ACCESS cycles before ack;
  // drop: grant only for one cycle; ab: cycle of a reset_req pulse (-1 none).
  // Cycle 0 is the cycle op_req_i first goes high.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] resp, input int gd, input int ad,
                         input bit drop, input int ab);
    int          a_cyc, d_exp, acc_exp;
    int          d_obs, req_n, acc_n, bad_n, halt_n;
    logic        e_exp;
    logic [31:0] r_exp;
    r_exp   = exp_rdata;
    e_exp   = 1'b0;
    a_cyc   = -1;
    acc_exp = 0;
    if (gd >= T) begin
      d_exp = 1 + T;
      e_exp = 1'b1;
    end else begin
      a_cyc = 2 + gd;
      if (drop && ad > 0) begin
        d_exp = a_cyc + 1; e_exp = 1'b1; acc_exp = 1;
      end else if (ad < T) begin
        d_exp = a_cyc + ad + 1; acc_exp = ad + 1;
        if (!we) r_exp = resp;
      end else begin
        d_exp = a_cyc + T; acc_exp = T; e_exp = 1'b1; r_exp = '0;
      end
    end
    if (ab >= 1 && ab < d_exp) begin
      d_exp   = ab + 1;
      e_exp   = 1'b1;
      r_exp   = exp_rdata;
      acc_exp = (a_cyc >= 0 && ab >= a_cyc) ? ab - a_cyc + 1 : 0;
    end

    @(negedge clk);
    op_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wdata;
    bus_rdata_i = resp; bus_gnt_i = 1'b0; bus_ack_i = 1'b0; reset_req_i = 1'b0;
    d_obs = -1; req_n = 0; acc_n = 0; bad_n = 0; halt_n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) chk("err_clear", 32'(err_o), 32'd0);
      if (bus_req_o) req_n++;
      if (halt_o) halt_n++;
      if (bus_addr_o != 32'd0) begin
        acc_n++;
        if (bus_addr_o !== addr || bus_wdata_o !== wdata || bus_we_o !== we) bad_n++;
      end else if (bus_we_o || bus_wdata_o != 32'd0) begin
        bad_n++;
      end
      if (d_obs < 0 && !busy_o) begin
        d_obs = k;
        op_req_i = 1'b0;
        chk("err", 32'(err_o), 32'(e_exp));
        chk("rdata", mem_rdata_o, r_exp);
      end
      bus_gnt_i   = (k >= 1 + gd) && (!drop || k == 1 + gd);
      bus_ack_i   = (a_cyc >= 0) && (k == a_cyc + ad);
      reset_req_i = (k == ab);
      if (d_obs >= 0 && k == d_obs + 3) break;
    end
    bus_gnt_i = 1'b0; bus_ack_i = 1'b0; reset_req_i = 1'b0; op_req_i = 1'b0;
    chk("done_cycle", d_obs, d_exp);
    chk("req_cycles", req_n, d_exp - 1);
    chk("access_cycles", acc_n, acc_exp);
    chk("bus_payload", bad_n, 0);
    chk("halt_cycles", halt_n, d_exp);
    exp_rdata = r_exp;
  endtask

  // reset_req_i pulses at cycles t1 and t2 (t2 < 0: none); each edge
  // makes core_rst_o high for the RC cycles that follow it.
  task automatic rst_pulse_test(input int t1, input int t2);
    int mism, hi, hi_exp, last;
    mism = 0; hi = 0; hi_exp = 0;
    last = ((t2 >= 0) ? t2 : t1) + RC + 4;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        bit e;
        e = (k > t1 && k <= t1 + RC) || (t2 >= 0 && k > t2 && k <= t2 + RC);
        if (core_rst_o !== e) mism++;
        if (e) hi_exp++;
        if (core_rst_o) hi++;
      end
      reset_req_i = (k == t1 || k == t2);
    end
    reset_req_i = 1'b0;
    chk("rst_shape", mism, 0);
    chk("rst_length", hi, hi_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; op_req_i = 1'b0; mem_we_i = 1'b0; halt_req_i = 1'b0; reset_req_i = 1'b0;
    mem_addr_i = '0; mem_wdata_i = '0; bus_gnt_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
    exp_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", mem_rdata_o, 32'd0);
    chk("rst_ctl", 32'({bus_req_o, bus_we_o, halt_o, core_rst_o, busy_o, err_o}), 32'd0);
    chk("rst_bus", bus_addr_o | bus_wdata_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 32'h0000_1000, 32'h0,         32'h1234_5678, 0, 0, 1'b0, -1);
    run_txn(1'b1, 32'h2000_0004, 32'hCAFE_F00D, 32'h5555_AAAA, 5, 2, 1'b0, -1);
    run_txn(1'b0, 32'h0000_3000, 32'h0,         32'h1111_2222, 20, 0, 1'b0, -1);
    run_txn(1'b0, 32'h0000_3004, 32'h0,         32'h0BAD_BEEF, 0, 20, 1'b0, -1);
    run_txn(1'b0, 32'h0000_3008, 32'h0,         32'h7777_0001, 1, T - 1, 1'b0, -1);
    run_txn(1'b0, 32'h0000_300C, 32'h0,         32'h7777_0002, T - 1, 0, 1'b0, -1);
    run_txn(1'b0, 32'h0000_3010, 32'h0,         32'h9999_0003, 2, 3, 1'b1, -1);
    run_txn(1'b0, 32'h0000_3014, 32'h0,         32'hABCD_0004, 0, 6, 1'b0, 4);
    run_txn(1'b1, 32'h0000_3018, 32'h1357_9BDF, 32'hABCD_0005, 5, 0, 1'b0, 3);

    @(negedge clk);
    halt_req_i = 1'b1;
    chk("halt_lag", 32'(halt_o), 32'd0);
    @(negedge clk);
    chk("halt_on", 32'(halt_o), 32'd1);
    halt_req_i = 1'b0;
    @(negedge clk);
    chk("halt_off", 32'(halt_o), 32'd0);

    repeat (RC + 4) @(negedge clk);
    rst_pulse_test(0, 10);
    for (int i = 0; i < 3; i++) begin
      int t1;
      t1 = $urandom_range(0, 5);
      rst_pulse_test(t1, t1 + $urandom_range(2, 20));
    end
    rst_pulse_test(1, -1);

    // Asynchronous reset in the middle of an access
    run_txn(1'b0, 32'h0000_5000, 32'h0, 32'hFEED_5000, 0, 0, 1'b0, -1);
    @(negedge clk);
    op_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_4000;
    mem_wdata_i = 32'h0000_4444; bus_gnt_i = 1'b1; bus_rdata_i = 32'hDEAD_4000;
    repeat (2) @(negedge clk);
    chk("pre_arst_addr", bus_addr_o, 32'h0000_4000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdata", mem_rdata_o, 32'd0);
    chk("arst_ctl", 32'({bus_req_o, bus_we_o, halt_o, core_rst_o, busy_o, err_o}), 32'd0);
    chk("arst_bus", bus_addr_o | bus_wdata_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; op_req_i = 1'b0; bus_gnt_i = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    run_txn(1'b0, 32'h0000_4100, 32'h0, 32'h600D_4100, 0, 1, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [31:0] addr, wdata, resp;
      int          gd, ad;
      bit          drop;
      we    = 1'($urandom_range(0, 1));
      addr  = $urandom | 32'h4;
      wdata = $urandom;
      resp  = $urandom;
      gd    = $urandom_range(0, T + 1);
      ad    = $urandom_range(0, T + 1);
      drop  = ($urandom_range(0, 7) == 0);
      run_txn(we, addr, wdata, resp, gd, ad, drop, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
